// File: rtl/matmul_mem_responder.sv
// rtl/matmul_mem_responder.sv - A/B operand and C result memories for the matmul engine
// Host preload/dump port with engine-priority arbitration and a session FSM.
module matmul_mem_responder #(
  parameter int DEPTH      = 16,
  parameter int C_EXPECTED = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        mem_read_en_A,
  input  logic [9:0]  mem_addr_A,
  output logic [31:0] mem_data_A,
  input  logic        mem_read_en_B,
  input  logic [9:0]  mem_addr_B,
  output logic [31:0] mem_data_B,
  input  logic        mem_write_en_C,
  input  logic [9:0]  mem_addr_C,
  input  logic [31:0] mem_data_C,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [9:0]  host_addr,
  input  logic [31:0] host_wdata,
  output logic        host_gnt,
  output logic        host_rvalid,
  output logic [31:0] host_rdata,
  input  logic        done_ack,
  output logic        busy,
  output logic        c_done,
  output logic [7:0]  c_write_cnt,
  output logic        err_addr
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [8:0] DEPTH_W = 9'(DEPTH);
  localparam logic [8:0] C_EXP_W = 9'(C_EXPECTED);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  logic [31:0] mem_a [DEPTH];
  logic [31:0] mem_b [DEPTH];
  logic [31:0] mem_c [DEPTH];

  logic [1:0]  state;
  logic        a_ok, b_ok, c_ok;
  logic        host_ok;
  logic        engine_act;
  logic        host_wr, host_rd;
  logic        c_legal_wr;
  logic [7:0]  cnt_inc;
  logic [31:0] host_word;
  logic [1:0]  host_region;

  function automatic logic in_region(input logic [9:0] a, input logic [1:0] r);
    return (a[9:8] == r) && ({1'b0, a[7:0]} < DEPTH_W);
  endfunction

  assign a_ok        = in_region(mem_addr_A, 2'd0);
  assign b_ok        = in_region(mem_addr_B, 2'd1);
  assign c_ok        = in_region(mem_addr_C, 2'd2);
  assign host_region = host_addr[9:8];
  assign host_ok     = (host_region != 2'd3) && ({1'b0, host_addr[7:0]} < DEPTH_W);

  // Engine always wins; during a session the host may only touch results.
  assign engine_act = mem_read_en_A | mem_read_en_B | mem_write_en_C;
  assign host_gnt   = host_req & ~engine_act & ~(busy & host_we & (host_region != 2'd2));
  assign host_wr    = host_gnt & host_we;
  assign host_rd    = host_gnt & ~host_we;
  assign c_legal_wr = mem_write_en_C & c_ok;

  assign busy   = (state == ST_ACTIVE);
  assign c_done = (state == ST_DONE);

  always_comb begin
    host_word = '0;
    if (host_ok) begin
      case (host_region)
        2'd0:    host_word = mem_a[host_addr[AW-1:0]];
        2'd1:    host_word = mem_b[host_addr[AW-1:0]];
        2'd2:    host_word = mem_c[host_addr[AW-1:0]];
        default: host_word = '0;
      endcase
    end
  end

  // Storage is deliberately left out of reset so operands survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (c_legal_wr)
      mem_c[mem_addr_C[AW-1:0]] <= mem_data_C;
    if (host_wr && host_ok) begin
      case (host_region)
        2'd0:    mem_a[host_addr[AW-1:0]] <= host_wdata;
        2'd1:    mem_b[host_addr[AW-1:0]] <= host_wdata;
        2'd2:    mem_c[host_addr[AW-1:0]] <= host_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_data_A  <= '0;
      mem_data_B  <= '0;
      host_rvalid <= 1'b0;
      host_rdata  <= '0;
      err_addr    <= 1'b0;
    end else begin
      host_rvalid <= host_rd;
      if (mem_read_en_A)
        mem_data_A <= a_ok ? mem_a[mem_addr_A[AW-1:0]] : '0;
      if (mem_read_en_B)
        mem_data_B <= b_ok ? mem_b[mem_addr_B[AW-1:0]] : '0;
      if (host_rd)
        host_rdata <= host_word;
      if ((mem_read_en_A & ~a_ok) | (mem_read_en_B & ~b_ok) |
          (mem_write_en_C & ~c_ok) | (host_gnt & ~host_ok))
        err_addr <= 1'b1;
    end
  end

  assign cnt_inc = (c_write_cnt == 8'hFF) ? 8'hFF : c_write_cnt + 8'd1;

  // A C write that opens a session also counts toward completion.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= ST_IDLE;
      c_write_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (engine_act) begin
            state       <= ST_ACTIVE;
            c_write_cnt <= c_legal_wr ? 8'd1 : 8'd0;
            if (c_legal_wr && (9'd1 >= C_EXP_W))
              state <= ST_DONE;
          end
        end
        ST_ACTIVE: begin
          if (c_legal_wr) begin
            c_write_cnt <= cnt_inc;
            if ({1'b0, cnt_inc} >= C_EXP_W)
              state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (done_ack)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_matmul_mem_responder.sv
// tb/tb_matmul_mem_responder.sv - scoreboard bench for matmul_mem_responder
module tb_matmul_mem_responder;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_read_en_A = 1'b0;
  logic [9:0]  mem_addr_A = '0;
  logic [31:0] mem_data_A;
  logic        mem_read_en_B = 1'b0;
  logic [9:0]  mem_addr_B = '0;
  logic [31:0] mem_data_B;
  logic        mem_write_en_C = 1'b0;
  logic [9:0]  mem_addr_C = '0;
  logic [31:0] mem_data_C = '0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [9:0]  host_addr = '0;
  logic [31:0] host_wdata = '0;
  logic        host_gnt;
  logic        host_rvalid;
  logic [31:0] host_rdata;
  logic        done_ack = 1'b0;
  logic        busy;
  logic        c_done;
  logic [7:0]  c_write_cnt;
  logic        err_addr;

  int total = 0;
  int bad = 0;
  int rv_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model[int];
  bit ok;

  matmul_mem_responder #(.DEPTH(DEPTH), .C_EXPECTED(1)) dut (
    .clk(clk), .rstn(rstn),
    .mem_read_en_A(mem_read_en_A), .mem_addr_A(mem_addr_A), .mem_data_A(mem_data_A),
    .mem_read_en_B(mem_read_en_B), .mem_addr_B(mem_addr_B), .mem_data_B(mem_data_B),
    .mem_write_en_C(mem_write_en_C), .mem_addr_C(mem_addr_C), .mem_data_C(mem_data_C),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .done_ack(done_ack), .busy(busy), .c_done(c_done),
    .c_write_cnt(c_write_cnt), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic bit legal(input logic [9:0] a);
    return (a[9:8] != 2'd3) && (int'(a[7:0]) < DEPTH);
  endfunction

  function automatic logic [31:0] model_rd(input logic [9:0] a);
    if (!legal(a) || !model.exists(int'(a))) return 32'h0;
    return model[int'(a)];
  endfunction

  // Host read responses are popped against the expectations queued at grant time.
  always @(negedge clk) begin
    if (host_rvalid) begin
      rv_cnt++;
      if (exp_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
      else check("host_rdata", host_rdata, exp_q.pop_front());
    end
  end

  task automatic host_access(input logic we, input logic [9:0] a, input logic [31:0] d,
                             input int budget, output bit granted);
    granted = 1'b0;
    @(negedge clk);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
    for (int i = 0; i < budget; i++) begin
      #1;
      if (host_gnt) begin
        granted = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (granted) begin
      if (!we) exp_q.push_back(model_rd(a));
      else if (legal(a)) model[int'(a)] = d;
      @(posedge clk);
      #1;
    end
    host_req = 1'b0; host_we = 1'b0;
  endtask

  task automatic eng_read(input logic ea, input logic [9:0] aa, input logic eb, input logic [9:0] ab);
    @(negedge clk);
    mem_read_en_A = ea; mem_addr_A = aa;
    mem_read_en_B = eb; mem_addr_B = ab;
    @(negedge clk);
    mem_read_en_A = 1'b0; mem_read_en_B = 1'b0;
  endtask

  task automatic eng_write_c(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_write_en_C = 1'b1; mem_addr_C = a; mem_data_C = d;
    @(negedge clk);
    mem_write_en_C = 1'b0;
    if (a[9:8] == 2'd2 && legal(a)) model[int'(a)] = d;
  endtask

  task automatic ack_done();
    @(negedge clk);
    done_ack = 1'b1;
    @(negedge clk);
    done_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_data_A"}, mem_data_A, 32'h0);
    check({tag, "_data_B"}, mem_data_B, 32'h0);
    check({tag, "_rvalid"}, {31'h0, host_rvalid}, 32'h0);
    check({tag, "_rdata"}, host_rdata, 32'h0);
    check({tag, "_cnt"}, {24'h0, c_write_cnt}, 32'h0);
    check({tag, "_c_done"}, {31'h0, c_done}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_err"}, {31'h0, err_addr}, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_before;
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Preload and engine read of both operand ports
    host_access(1'b1, 10'h000, 32'h04030201, 4, ok);
    check("wr_a_gnt", {31'h0, ok}, 32'd1);
    host_access(1'b1, 10'h101, 32'h08070605, 4, ok);
    check("wr_b_gnt", {31'h0, ok}, 32'd1);
    eng_read(1'b1, 10'h000, 1'b1, 10'h101);
    check("rd_a", mem_data_A, 32'h04030201);
    check("rd_b", mem_data_B, 32'h08070605);
    check("busy_start", {31'h0, busy}, 32'd1);
    @(negedge clk); @(negedge clk);
    check("rd_a_hold", mem_data_A, 32'h04030201);
    check("rd_b_hold", mem_data_B, 32'h08070605);

    // Operand writes blocked while busy, granted after completion
    host_access(1'b1, 10'h002, 32'h12345678, 3, ok);
    check("wr_busy_blocked", {31'h0, ok}, 32'd0);
    check("cnt_cleared", {24'h0, c_write_cnt}, 32'd0);
    eng_write_c(10'h201, 32'h55AA55AA);
    check("s1_cnt", {24'h0, c_write_cnt}, 32'd1);
    check("s1_done", {31'h0, c_done}, 32'd1);
    check("s1_busy", {31'h0, busy}, 32'd0);
    ack_done();
    check("ack_done", {31'h0, c_done}, 32'd0);
    host_access(1'b1, 10'h002, 32'h12345678, 4, ok);
    check("wr_after_ack", {31'h0, ok}, 32'd1);
    host_access(1'b0, 10'h002, 32'h0, 4, ok);

    // C write opens and completes a session from idle
    eng_write_c(10'h200, 32'h0A0B0C0D);
    check("s2_cnt", {24'h0, c_write_cnt}, 32'd1);
    check("s2_done", {31'h0, c_done}, 32'd1);
    check("s2_busy", {31'h0, busy}, 32'd0);
    host_access(1'b0, 10'h200, 32'h0, 4, ok);
    host_access(1'b0, 10'h201, 32'h0, 4, ok);
    ack_done();

    // Offset boundary and illegal addresses
    host_access(1'b1, 10'h00F, 32'hDEADBEEF, 4, ok);
    eng_read(1'b1, 10'h00F, 1'b0, 10'h0);
    check("rd_last_word", mem_data_A, 32'hDEADBEEF);
    check("err_clear", {31'h0, err_addr}, 32'd0);
    eng_read(1'b1, 10'h010, 1'b0, 10'h0);
    check("rd_past_depth", mem_data_A, 32'h0);
    check("err_depth", {31'h0, err_addr}, 32'd1);
    eng_read(1'b1, 10'h000, 1'b0, 10'h0);
    eng_read(1'b1, 10'h105, 1'b0, 10'h0);
    check("rd_a_wrong_region", mem_data_A, 32'h0);
    host_access(1'b0, 10'h310, 32'h0, 4, ok);
    eng_write_c(10'h210, 32'hFFFFFFFF);
    check("illegal_c_not_counted", {24'h0, c_write_cnt}, 32'd0);
    check("illegal_c_busy", {31'h0, busy}, 32'd1);
    check("err_sticky", {31'h0, err_addr}, 32'd1);

    // Host held off by three consecutive engine strobes
    @(negedge clk);
    rv_before = rv_cnt;
    host_req = 1'b1; host_we = 1'b0; host_addr = 10'h000;
    mem_read_en_A = 1'b1; mem_addr_A = 10'h000;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("gnt_engine_busy", {31'h0, host_gnt}, 32'd0);
      @(negedge clk);
    end
    mem_read_en_A = 1'b0;
    #1;
    check("gnt_first_idle", {31'h0, host_gnt}, 32'd1);
    if (host_gnt) exp_q.push_back(model_rd(10'h000));
    @(posedge clk);
    #1;
    host_req = 1'b0;
    repeat (3) @(negedge clk);
    check("one_access", rv_cnt - rv_before, 32'd1);

    // Asynchronous reset mid-session; storage survives
    check("pre_reset_data", mem_data_A, 32'h04030201);
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    rstn = 1'b1;
    host_access(1'b0, 10'h000, 32'h0, 4, ok);
    host_access(1'b0, 10'h101, 32'h0, 4, ok);
    host_access(1'b0, 10'h200, 32'h0, 4, ok);
    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
